// File: rtl/admo_ex_stage.sv
// Execute stage: operand bypass/select, ALU, single-entry output register, retire counter.
// Latency 1 cycle from accept to out_valid_o.
// Backpressure: in_ready_o drops while a held result is stalled by out_ready_i or flush_i.

module admo_alu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [3:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result
);
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;

   // Codes not handled here pass operand A through.
   always_comb begin
      result = a;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLL: result = a << b[4:0];
         ALU_SRL: result = a >> b[4:0];
         ALU_SRA: result = $signed(a) >>> b[4:0];
         default: result = a;
      endcase
   end
endmodule

module admo_ex_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_WIDTH   = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [3:0]            in_operator_i,
   input  logic                  in_cmp_unsigned_i,
   input  logic [RD_WIDTH-1:0]   in_rs1_addr_i,
   input  logic [RD_WIDTH-1:0]   in_rs2_addr_i,
   input  logic [DATA_WIDTH-1:0] in_rs1_data_i,
   input  logic [DATA_WIDTH-1:0] in_rs2_data_i,
   input  logic [DATA_WIDTH-1:0] in_pc_i,
   input  logic [DATA_WIDTH-1:0] in_imm_i,
   input  logic                  in_use_pc_i,
   input  logic                  in_use_imm_i,
   input  logic [RD_WIDTH-1:0]   in_rd_i,
   input  logic                  in_we_i,
   input  logic                  byp_valid_i,
   input  logic [RD_WIDTH-1:0]   byp_rd_i,
   input  logic [DATA_WIDTH-1:0] byp_data_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_result_o,
   output logic [RD_WIDTH-1:0]   out_rd_o,
   output logic                  out_we_o,
   output logic [31:0]           retire_cnt_o
);
   localparam logic [3:0] ALU_LTS = 4'd8;

   logic                  accept;
   logic                  xfer;
   logic                  lt;
   logic [DATA_WIDTH-1:0] rs1_val;
   logic [DATA_WIDTH-1:0] rs2_val;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic [DATA_WIDTH-1:0] alu_res;
   logic [DATA_WIDTH-1:0] result;

   assign in_ready_o = !rst_i && !flush_i && (!out_valid_o || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;
   assign xfer       = out_valid_o && out_ready_i;

   // x0 is hardwired, so a writeback targeting it must never be forwarded.
   assign rs1_val = (byp_valid_i && (byp_rd_i == in_rs1_addr_i) && (in_rs1_addr_i != '0))
                    ? byp_data_i : in_rs1_data_i;
   assign rs2_val = (byp_valid_i && (byp_rd_i == in_rs2_addr_i) && (in_rs2_addr_i != '0))
                    ? byp_data_i : in_rs2_data_i;

   assign op_a = in_use_pc_i  ? in_pc_i  : rs1_val;
   assign op_b = in_use_imm_i ? in_imm_i : rs2_val;

   admo_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op     (in_operator_i),
      .a      (op_a),
      .b      (op_b),
      .result (alu_res)
   );

   assign lt     = in_cmp_unsigned_i ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
   assign result = (in_operator_i == ALU_LTS) ? {{(DATA_WIDTH-1){1'b0}}, lt} : alu_res;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o  <= 1'b0;
         out_result_o <= '0;
         out_rd_o     <= '0;
         out_we_o     <= 1'b0;
         retire_cnt_o <= '0;
      end else begin
         if (flush_i) begin
            out_valid_o <= 1'b0;
         end else if (accept) begin
            out_valid_o  <= 1'b1;
            out_result_o <= result;
            out_rd_o     <= in_rd_i;
            out_we_o     <= in_we_i;
         end else if (xfer) begin
            out_valid_o <= 1'b0;
         end
         // A transfer coinciding with a flush is discarded and not counted.
         if (xfer && !flush_i) begin
            retire_cnt_o <= retire_cnt_o + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_admo_ex_stage.sv
// Directed-vector bench for admo_ex_stage.
module tb_admo_ex_stage;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
   localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, LTS = 4'd8, UNDEF = 4'd12;

   logic        clk = 1'b0;
   logic        rst_i, in_valid_i, in_ready_o, in_cmp_unsigned_i;
   logic [3:0]  in_operator_i;
   logic [4:0]  in_rs1_addr_i, in_rs2_addr_i, in_rd_i, byp_rd_i, out_rd_o;
   logic [31:0] in_rs1_data_i, in_rs2_data_i, in_pc_i, in_imm_i, byp_data_i;
   logic        in_use_pc_i, in_use_imm_i, in_we_i, byp_valid_i, flush_i;
   logic        out_valid_o, out_ready_i, out_we_o;
   logic [31:0] out_result_o, retire_cnt_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_cnt = 0;

   always #5 clk = ~clk;

   admo_ex_stage #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
      .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_operator_i(in_operator_i), .in_cmp_unsigned_i(in_cmp_unsigned_i),
      .in_rs1_addr_i(in_rs1_addr_i), .in_rs2_addr_i(in_rs2_addr_i),
      .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i),
      .in_pc_i(in_pc_i), .in_imm_i(in_imm_i), .in_use_pc_i(in_use_pc_i),
      .in_use_imm_i(in_use_imm_i), .in_rd_i(in_rd_i), .in_we_i(in_we_i),
      .byp_valid_i(byp_valid_i), .byp_rd_i(byp_rd_i), .byp_data_i(byp_data_i),
      .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_result_o(out_result_o), .out_rd_o(out_rd_o), .out_we_o(out_we_o),
      .retire_cnt_o(retire_cnt_o)
   );

   // Register-register op with rs1=x1, rs2=x2 and no bypass.
   task automatic drive_rr(input logic [3:0] op, input logic cu, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
      in_valid_i = 1'b1; in_operator_i = op; in_cmp_unsigned_i = cu;
      in_rs1_addr_i = 5'd1; in_rs2_addr_i = 5'd2; in_rs1_data_i = a; in_rs2_data_i = b;
      in_use_pc_i = 1'b0; in_use_imm_i = 1'b0; in_rd_i = rd; in_we_i = 1'b1;
      byp_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; in_pc_i = '0; in_imm_i = '0;
      byp_rd_i = '0; byp_data_i = '0;
      drive_rr(ADD, 1'b0, 32'd1, 32'd2, 5'd1);
      repeat (2) @(negedge clk);
      n_vec++;
      if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_o); end
      n_vec++;
      if ({out_valid_o, out_we_o, out_rd_o, out_result_o, retire_cnt_o} !== 71'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b we=%b rd=%0d res=%h cnt=%h expected all 0",
                  out_valid_o, out_we_o, out_rd_o, out_result_o, retire_cnt_o);
      end
      in_valid_i = 1'b0; rst_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      out_ready_i = 1'b1;
      drive_rr(ADD, 1'b0, 32'd5, 32'd7, 5'd4);
      n_vec++;
      if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready_o); end
      @(negedge clk);
      n_vec++;
      if ({out_valid_o, out_result_o, out_rd_o, out_we_o} !== {1'b1, 32'h0000000C, 5'd4, 1'b1}) begin
         n_err++;
         $display("FAIL b2b_add: got v=%b res=%h rd=%0d we=%b expected v=1 res=0000000c rd=4 we=1",
                  out_valid_o, out_result_o, out_rd_o, out_we_o);
      end
      drive_rr(SUB, 1'b0, 32'd3, 32'd5, 5'd6);
      in_we_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({out_valid_o, out_result_o, out_rd_o, out_we_o} !== {1'b1, 32'hFFFFFFFE, 5'd6, 1'b0}) begin
         n_err++;
         $display("FAIL b2b_sub: got v=%b res=%h rd=%0d we=%b expected v=1 res=fffffffe rd=6 we=0",
                  out_valid_o, out_result_o, out_rd_o, out_we_o);
      end
      in_valid_i = 1'b0;
      @(negedge clk);
      exp_cnt = 32'd2;
      n_vec++;
      if (out_valid_o !== 1'b0 || retire_cnt_o !== exp_cnt) begin
         n_err++;
         $display("FAIL b2b_drain: got v=%b cnt=%h expected v=0 cnt=%h", out_valid_o, retire_cnt_o, exp_cnt);
      end
   endtask

   task automatic test_backpressure;
      out_ready_i = 1'b0;
      drive_rr(XOR_, 1'b0, 32'h0000F0F0, 32'h00000FF0, 5'd7);
      @(negedge clk);
      drive_rr(OR_, 1'b0, 32'd1, 32'd2, 5'd8);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_result_o !== 32'h0000FF00 || out_rd_o !== 5'd7) begin
            n_err++;
            $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b res=%h rd=%0d expected rdy=0 v=1 res=0000ff00 rd=7",
                     i, in_ready_o, out_valid_o, out_result_o, out_rd_o);
         end
         @(negedge clk);
      end
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      @(negedge clk);
      exp_cnt = exp_cnt + 1;
      n_vec++;
      if (out_valid_o !== 1'b0 || retire_cnt_o !== exp_cnt) begin
         n_err++;
         $display("FAIL backpressure_release: got v=%b cnt=%h expected v=0 cnt=%h", out_valid_o, retire_cnt_o, exp_cnt);
      end
   endtask

   task automatic test_bypass;
      logic [31:0] exp_res [4] = '{32'h11, 32'h9A, 32'h9A, 32'hFFFFFFE0};
      out_ready_i = 1'b1;
      drive_rr(ADD, 1'b0, 32'h99, 32'h0, 5'd3);
      in_rs1_addr_i = 5'd3; in_use_imm_i = 1'b1; in_imm_i = 32'd1;
      byp_valid_i = 1'b1; byp_rd_i = 5'd3; byp_data_i = 32'h10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++;
         if (out_valid_o !== 1'b1 || out_result_o !== exp_res[i]) begin
            n_err++;
            $display("FAIL bypass[%0d]: got v=%b res=%h expected v=1 res=%h", i, out_valid_o, out_result_o, exp_res[i]);
         end
         case (i)
            0: begin in_rs1_addr_i = 5'd0; byp_rd_i = 5'd0; end
            1: begin in_rs1_addr_i = 5'd3; byp_rd_i = 5'd3; byp_valid_i = 1'b0; end
            2: begin  // rs2 path: 0x10 - bypassed 0x30
               drive_rr(SUB, 1'b0, 32'h10, 32'h5, 5'd9);
               in_rs2_addr_i = 5'd9; byp_valid_i = 1'b1; byp_rd_i = 5'd9; byp_data_i = 32'h30;
            end
            default: in_valid_i = 1'b0;
         endcase
      end
      @(negedge clk);
      exp_cnt = exp_cnt + 4;
      byp_valid_i = 1'b0;
      n_vec++;
      if (retire_cnt_o !== exp_cnt) begin
         n_err++; $display("FAIL bypass_count: got %h expected %h", retire_cnt_o, exp_cnt);
      end
   endtask

   task automatic test_alu_ops;
      logic [3:0]  v_op [13] = '{ADD, SUB, AND_, OR_, XOR_, SLL, SRL, SRA, LTS, LTS, LTS, LTS, UNDEF};
      logic        v_cu [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
      logic [31:0] v_a  [13] = '{32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0000000, 32'hAAAA5555, 32'h1,
                                 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
                                 32'h1, 32'h12345678};
      logic [31:0] v_b  [13] = '{32'h1, 32'h1, 32'h0FF00FF0, 32'h0000000F, 32'hFFFF0000, 32'h21,
                                 32'h4, 32'h4, 32'h1, 32'h1, 32'h80000000, 32'h2, 32'h5};
      logic [31:0] v_r  [13] = '{32'h0, 32'hFFFFFFFF, 32'h00F000F0, 32'hF000000F, 32'h55555555, 32'h2,
                                 32'h08000000, 32'hF8000000, 32'h1, 32'h0, 32'h0, 32'h1, 32'h12345678};
      out_ready_i = 1'b1;
      for (int i = 0; i < 13; i++) begin
         drive_rr(v_op[i], v_cu[i], v_a[i], v_b[i], 5'd10);
         @(negedge clk);
         n_vec++;
         if (out_valid_o !== 1'b1 || out_result_o !== v_r[i]) begin
            n_err++;
            $display("FAIL alu_op[%0d] op=%0d: got v=%b res=%h expected v=1 res=%h",
                     i, v_op[i], out_valid_o, out_result_o, v_r[i]);
         end
      end
      // PC as operand A with immediate B.
      drive_rr(ADD, 1'b0, 32'h55, 32'h66, 5'd11);
      in_use_pc_i = 1'b1; in_pc_i = 32'h00001000; in_use_imm_i = 1'b1; in_imm_i = 32'd4;
      @(negedge clk);
      n_vec++;
      if (out_result_o !== 32'h00001004) begin
         n_err++; $display("FAIL alu_pc_imm: got %h expected 00001004", out_result_o);
      end
      in_valid_i = 1'b0; in_use_pc_i = 1'b0;
      @(negedge clk);
      exp_cnt = exp_cnt + 14;
      n_vec++;
      if (retire_cnt_o !== exp_cnt) begin
         n_err++; $display("FAIL alu_count: got %h expected %h", retire_cnt_o, exp_cnt);
      end
   endtask

   task automatic test_flush;
      out_ready_i = 1'b0;
      drive_rr(ADD, 1'b0, 32'd2, 32'd2, 5'd12);
      @(negedge clk);
      out_ready_i = 1'b1; flush_i = 1'b1;
      drive_rr(ADD, 1'b0, 32'd9, 32'd9, 5'd13);
      n_vec++;
      if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b expected 0", in_ready_o); end
      @(negedge clk);
      n_vec++;
      if (out_valid_o !== 1'b0 || retire_cnt_o !== exp_cnt) begin
         n_err++;
         $display("FAIL flush_drop: got v=%b cnt=%h expected v=0 cnt=%h", out_valid_o, retire_cnt_o, exp_cnt);
      end
      flush_i = 1'b0; in_valid_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid_o !== 1'b0 || retire_cnt_o !== exp_cnt) begin
         n_err++;
         $display("FAIL flush_after: got v=%b cnt=%h expected v=0 cnt=%h", out_valid_o, retire_cnt_o, exp_cnt);
      end
   endtask

   task automatic test_reset_wrap;
      out_ready_i = 1'b0;
      drive_rr(OR_, 1'b0, 32'hDEAD0000, 32'h0000BEEF, 5'd14);
      @(negedge clk);
      rst_i = 1'b1; flush_i = 1'b1;
      n_vec++;
      if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL midreset_in_ready: got %b expected 0", in_ready_o); end
      @(negedge clk);
      n_vec++;
      if ({out_valid_o, out_we_o, out_rd_o, out_result_o, retire_cnt_o} !== 71'd0) begin
         n_err++;
         $display("FAIL midreset_outputs: got v=%b we=%b rd=%0d res=%h cnt=%h expected all 0",
                  out_valid_o, out_we_o, out_rd_o, out_result_o, retire_cnt_o);
      end
      rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      force dut.retire_cnt_o = 32'hFFFFFFFE;
      #1;
      release dut.retire_cnt_o;
      drive_rr(ADD, 1'b0, 32'd1, 32'd1, 5'd15);
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (retire_cnt_o !== 32'hFFFFFFFF) begin
         n_err++; $display("FAIL wrap_max: got %h expected ffffffff", retire_cnt_o);
      end
      in_valid_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if (retire_cnt_o !== 32'h0 || out_valid_o !== 1'b0) begin
         n_err++; $display("FAIL wrap_zero: got cnt=%h v=%b expected cnt=0 v=0", retire_cnt_o, out_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_bypass();
      test_alu_ops();
      test_flush();
      test_reset_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
